relu_writeback_scheduler: RTL and testbench

Sequences quantized ReLU write-back for one systolic output stage. Accepts one row of CELL_AMOUNT raw accumulator results at a time, requantizes and ReLU-clamps each lane, and serializes the lanes onto a single output-buffer write port with computed addresses. Sits between the processing-cell array and the activation buffer, and replaces per-cell index counting with one central scheduler that is configured per layer.

---
 rtl/relu_writeback_scheduler_pkg.sv | 48 ++++
 rtl/relu_requant_lane.sv | 14 +
 rtl/relu_writeback_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_relu_writeback_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_writeback_scheduler_pkg.sv
// Shared types, widths and the requantize/ReLU-clamp function for the
// ReLU write-back scheduler.
package relu_writeback_scheduler_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned RESULT_WIDTH  = 16;
    localparam int unsigned CELL_AMOUNT   = 4;
    localparam int unsigned INDEX_WIDTH   = 10;
    localparam int unsigned ADDR_WIDTH    = 10;
    localparam int unsigned SHIFT_WIDTH   = 5;
    localparam int unsigned ACC_EXT_WIDTH = RESULT_WIDTH + 2;
    localparam int unsigned LANE_WIDTH    = $clog2(CELL_AMOUNT);
    localparam int unsigned ROW_WIDTH     = CELL_AMOUNT * RESULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Arithmetic shift, add zero point, clamp to [zero_point, 2^DATA_WIDTH-1].
    function automatic logic [DATA_WIDTH-1:0] requant_clamp(
        input logic signed [RESULT_WIDTH-1:0] r,
        input logic        [SHIFT_WIDTH-1:0]  shift,
        input logic        [DATA_WIDTH-1:0]   zp
    );
        logic signed [RESULT_WIDTH-1:0]  t;
        logic signed [ACC_EXT_WIDTH-1:0] zp_ext;
        logic signed [ACC_EXT_WIDTH-1:0] q_max;
        logic signed [ACC_EXT_WIDTH-1:0] q;
        logic        [DATA_WIDTH-1:0]    res;
        // Shifting a signed value by >= its width fills with the sign bit.
        t      = r >>> shift;
        zp_ext = $signed({{(ACC_EXT_WIDTH-DATA_WIDTH){1'b0}}, zp});
        q_max  = $signed({{(ACC_EXT_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});
        q      = ACC_EXT_WIDTH'(t) + zp_ext;
        if (q < zp_ext) begin
            res = zp;
        end else if (q > q_max) begin
            res = {DATA_WIDTH{1'b1}};
        end else begin
            res = q[DATA_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/relu_requant_lane.sv
// Combinational requantize + ReLU clamp for one accumulator lane.
// Ports: result_i (signed accumulator), shift_i, zero_point_i -> act_c_o.
module relu_requant_lane
    import relu_writeback_scheduler_pkg::*;
(
    input  logic [RESULT_WIDTH-1:0] result_i,
    input  logic [SHIFT_WIDTH-1:0]  shift_i,
    input  logic [DATA_WIDTH-1:0]   zero_point_i,
    output logic [DATA_WIDTH-1:0]   act_c_o
);

    assign act_c_o = requant_clamp($signed(result_i), shift_i, zero_point_i);

endmodule

// File: rtl/relu_writeback_scheduler.sv
// Central ReLU write-back scheduler: accepts one row of CELL_AMOUNT
// accumulator results, requantizes each lane and serializes the lanes onto
// a single output-buffer write port with computed addresses.
// Ports: clk/rst_n; start + cfg_* (layer config); row_valid/row_ready/
// row_data (row input); wr_en/wr_addr/wr_data/wr_ready (buffer write);
// busy, done (layer status). All outputs registered.
module relu_writeback_scheduler
    import relu_writeback_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [INDEX_WIDTH-1:0] cfg_row_count,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [DATA_WIDTH-1:0]  cfg_zero_point,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [ROW_WIDTH-1:0]   row_data,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_ready,
    output logic                   busy,
    output logic                   done
);

    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(CELL_AMOUNT - 1);

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] row_idx_q, row_idx_d;
    logic [LANE_WIDTH-1:0]  lane_q, lane_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [INDEX_WIDTH-1:0] rows_q, rows_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  zp_q, zp_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;

    logic                   row_ready_q, row_ready_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [ROW_WIDTH-1:0]    row_src_c;
    logic [RESULT_WIDTH-1:0] lane_word_c;
    logic [DATA_WIDTH-1:0]   lane_act_c;
    logic [ADDR_WIDTH-1:0]   addr_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_idx_q <= '0;
            lane_q    <= '0;
            base_q    <= '0;
            rows_q    <= '0;
            shift_q   <= '0;
            zp_q      <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            lane_q    <= lane_d;
            base_q    <= base_d;
            rows_q    <= rows_d;
            shift_q   <= shift_d;
            zp_q      <= zp_d;
            row_q     <= row_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        lane_d    = lane_q;
        base_d    = base_q;
        rows_d    = rows_q;
        shift_d   = shift_q;
        zp_d      = zp_q;
        row_d     = row_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = cfg_base_addr;
                    rows_d    = cfg_row_count;
                    shift_d   = cfg_shift;
                    zp_d      = cfg_zero_point;
                    row_idx_d = '0;
                    lane_d    = '0;
                    state_d   = (cfg_row_count == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (row_valid) begin
                    row_d   = row_data;
                    lane_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_ready) begin
                    if (lane_q == LAST_LANE) begin
                        if (row_idx_q == rows_q - INDEX_WIDTH'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            row_idx_d = row_idx_q + INDEX_WIDTH'(1);
                            state_d   = ST_COLLECT;
                        end
                    end else begin
                        lane_d = lane_q + LANE_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                // Stay until the done pulse has been presented.
                if (done_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane select: on the row handshake the word comes straight from row_data.
    assign row_src_c   = (state_q == ST_COLLECT) ? row_data : row_q;
    assign lane_word_c = row_src_c[32'(lane_d) * RESULT_WIDTH +: RESULT_WIDTH];
    assign addr_c      = ADDR_WIDTH'(32'(base_q) + 32'(row_idx_d) * CELL_AMOUNT + 32'(lane_d));

    relu_requant_lane u_lane (
        .result_i     (lane_word_c),
        .shift_i      (shift_q),
        .zero_point_i (zp_q),
        .act_c_o      (lane_act_c)
    );

    // Output next values, decoded from the next state.
    always_comb begin
        row_ready_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        row_ready_d = (state_d == ST_COLLECT);
        busy_d      = (state_d != ST_IDLE);
        // Entering DONE straight from IDLE (empty layer) delays the pulse a cycle.
        done_d      = (state_d == ST_DONE) && (state_q != ST_IDLE);
        if (state_d == ST_DRAIN) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_c;
            wr_data_d = lane_act_c;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            row_ready_q <= row_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign row_ready = row_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_relu_writeback_scheduler.sv
// Directed, table-driven bench for relu_writeback_scheduler.
module tb_relu_writeback_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  cfg_base_addr;
    logic [9:0]  cfg_row_count;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_zero_point;
    logic        row_valid;
    logic        row_ready;
    logic [63:0] row_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;

    relu_writeback_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_row_count  (cfg_row_count),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
        .row_valid      (row_valid),
        .row_ready      (row_ready),
        .row_data       (row_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] row;
        logic [4:0]  shift;
        logic [7:0]  zp;
        logic [9:0]  base;
        logic [31:0] exp;   // expected outputs, lane 0 in the low byte
    } vec_t;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int rows_acc;
    int wr_seen;
    int last_wr_cyc;
    bit last_acc_wr;
    bit last_acc_row;
    bit perturbed;
    int got_addr[$];
    int got_data[$];
    int exp_addr[$];
    int exp_data[$];
    logic [63:0] row_src[$];
    bit rdy_pat[$];

    function automatic logic [63:0] pack(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] pack8(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: record handshakes seen this cycle, advance, check write hold.
    task automatic tick();
        bit        hold;
        logic [9:0] ha;
        logic [7:0] hd;
        hold = wr_en && !wr_ready;
        ha   = wr_addr;
        hd   = wr_data;
        last_acc_wr  = wr_en && wr_ready;
        last_acc_row = row_ready && row_valid;
        if (last_acc_wr) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            last_wr_cyc = cyc;
        end
        if (last_acc_row) rows_acc++;
        if (wr_en) wr_seen++;
        @(posedge clk);
        #1;
        cyc++;
        if (hold) begin
            chk("hold_wr_en", wr_en, 1);
            chk("hold_wr_addr", wr_addr, ha);
            chk("hold_wr_data", wr_data, hd);
        end
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        rows_acc = 0;
        wr_seen  = 0;
        last_wr_cyc = -1;
    endtask

    // Run a full layer from row_src, compare against exp_addr/exp_data.
    task automatic run_layer(input int base, input int rows, input int shift,
                             input int zp, input bit perturb);
        int done_c;
        clear_log();
        perturbed      = 1'b0;
        cfg_base_addr  = 10'(base);
        cfg_row_count  = 10'(rows);
        cfg_shift      = 5'(shift);
        cfg_zero_point = 8'(zp);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_row_ready", row_ready, 1);
        row_valid = 1'b1;
        row_data  = row_src[0];
        done_c = -1;
        for (int i = 0; i < 400 && done_c < 0; i++) begin
            if (wr_en && rdy_pat.size() > 0) wr_ready = rdy_pat.pop_front();
            else wr_ready = 1'b1;
            if (perturb && wr_en && !perturbed) begin
                start          = 1'b1;
                cfg_base_addr  = 10'd500;
                cfg_row_count  = 10'd2;
                cfg_shift      = 5'd5;
                cfg_zero_point = 8'd77;
                perturbed      = 1'b1;
            end
            tick();
            start = 1'b0;
            if (last_acc_row && rows_acc < row_src.size()) row_data = row_src[rows_acc];
            if (last_acc_wr && (got_addr.size() % 4 == 0) && got_addr.size() < rows * 4)
                chk("row_ready_reassert", row_ready, 1);
            if (done) done_c = cyc;
        end
        wr_ready  = 1'b1;
        row_valid = 1'b0;
        if (done_c < 0) chk("done_timeout", 0, 1);
        else begin
            chk("done_after_last_wr", done_c, last_wr_cyc + 1);
            chk("busy_at_done", busy, 1);
        end
        chk("write_count", got_addr.size(), exp_addr.size());
        chk("rows_accepted", rows_acc, rows);
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            chk($sformatf("wr_addr[%0d]", i), got_addr[i], exp_addr[i]);
            chk($sformatf("wr_data[%0d]", i), got_data[i], exp_data[i]);
        end
        tick();
        chk("done_pulse_end", done, 0);
        chk("busy_end", busy, 0);
    endtask

    task automatic load_vec(input vec_t v);
        logic [31:0] e;
        row_src.delete();
        row_src.push_back(v.row);
        exp_addr.delete();
        exp_data.delete();
        e = v.exp;
        for (int l = 0; l < 4; l++) begin
            exp_addr.push_back((int'(v.base) + l) % 1024);
            exp_data.push_back(int'(e[l*8 +: 8]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_row_ready"}, row_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{row: pack(100, -8, 3, 1000),            shift: 5'd2,  zp: 8'd10,  base: 10'd0,    exp: pack8(35, 10, 10, 255)};
        vecs[1] = '{row: pack(-5, -32768, 32767, 0),        shift: 5'd31, zp: 8'd0,   base: 10'd100,  exp: pack8(0, 0, 0, 0)};
        vecs[2] = '{row: pack(255, 256, -1, 0),             shift: 5'd0,  zp: 8'd0,   base: 10'd1023, exp: pack8(255, 255, 0, 0)};
        vecs[3] = '{row: pack(80, -80, 1200, 7),            shift: 5'd3,  zp: 8'd20,  base: 10'd512,  exp: pack8(30, 20, 170, 20)};
        vecs[4] = '{row: pack(254, 256, -2, 300),           shift: 5'd1,  zp: 8'd128, base: 10'd7,    exp: pack8(255, 255, 128, 255)};

        rst_n = 1'b0; start = 1'b0; cfg_base_addr = '0; cfg_row_count = '0;
        cfg_shift = '0; cfg_zero_point = '0; row_valid = 1'b0; row_data = '0;
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #3 rst_n = 1'b1;
        tick();

        // Single-row layers from the vector table.
        for (int v = 0; v < 5; v++) begin
            load_vec(vecs[v]);
            run_layer(int'(vecs[v].base), 1, int'(vecs[v].shift), int'(vecs[v].zp), 1'b0);
        end

        // Three rows with address wrap from 1020.
        row_src.delete(); exp_addr.delete(); exp_data.delete();
        for (int k = 0; k < 3; k++) begin
            row_src.push_back(pack(k*4+1, k*4+2, k*4+3, k*4+4));
            for (int l = 0; l < 4; l++) begin
                exp_addr.push_back((1020 + k*4 + l) % 1024);
                exp_data.push_back(k*4 + l + 1);
            end
        end
        run_layer(1020, 3, 0, 0, 1'b0);

        // wr_ready toggled 1,0,0,1 during the drain.
        row_src.delete(); exp_addr.delete(); exp_data.delete();
        row_src.push_back(pack(1, 2, 3, 4));
        for (int l = 0; l < 4; l++) begin
            exp_addr.push_back(40 + l);
            exp_data.push_back(l + 1);
        end
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_layer(40, 1, 0, 0, 1'b0);

        // start with other config during the drain must be ignored.
        load_vec(vecs[0]);
        run_layer(0, 1, 2, 10, 1'b1);

        // Asynchronous reset after two lanes have been written.
        clear_log();
        cfg_base_addr = 10'd200; cfg_row_count = 10'd1; cfg_shift = '0; cfg_zero_point = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        row_valid = 1'b1;
        row_data  = pack(5, 6, 7, 8);
        for (int i = 0; i < 20 && got_addr.size() < 2; i++) tick();
        row_valid = 1'b0;
        chk("pre_reset_writes", got_addr.size(), 2);
        if (got_addr.size() >= 2) begin
            chk("pre_reset_addr0", got_addr[0], 200);
            chk("pre_reset_addr1", got_addr[1], 201);
        end
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        #2 rst_n = 1'b1;
        tick();
        row_src.delete(); exp_addr.delete(); exp_data.delete();
        row_src.push_back(pack(9, 10, 11, 12));
        for (int l = 0; l < 4; l++) begin
            exp_addr.push_back(300 + l);
            exp_data.push_back(9 + l);
        end
        run_layer(300, 1, 0, 0, 1'b0);

        // Empty layer: done two cycles after start, no writes.
        clear_log();
        cfg_row_count = 10'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rows0_busy_n1", busy, 1);
        chk("rows0_done_n1", done, 0);
        chk("rows0_row_ready_n1", row_ready, 0);
        tick();
        chk("rows0_done_n2", done, 1);
        tick();
        chk("rows0_done_n3", done, 0);
        chk("rows0_busy_n3", busy, 0);
        tick();
        chk("rows0_no_writes", wr_seen, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
